uart_rx: RTL and testbench

Serial UART receiver (8N1, LSB first) feeding the code-download byte stream (rx_valid/rx_data) into program RAM.
- Samples the asynchronous rx pin and recovers bytes by mid-bit sampling.
- Emits one single-cycle rx_valid pulse per correctly framed byte.
- Flags bad stop bits on rx_frame_err and does not deliver those bytes.

---
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, for the code-download byte stream.
//
// The asynchronous i_rx pin is passed through a SYNC_STAGES-deep flop chain;
// every decision below uses only the synchronized copy (rxs).
// A frame is recovered by sampling the start bit at its midpoint, then every
// CLKS_PER_BIT cycles after that for the eight data bits and the stop bit.
//
// Output handshake: rx_valid is a single-cycle pulse with no ready/backpressure.
// rx_data is updated in the same cycle that rx_valid is high and then held
// until the next good byte, so the consumer must take every pulse. rx_frame_err
// is a separate single-cycle pulse. It never coincides with rx_valid, and it
// leaves rx_data untouched.
//
// dbg_state mirrors the FSM state register so checkers can observe it.

module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Last count of the half-bit wait in START (mid start bit).
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Last count of a full bit period in DATA / STOP.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchronizer chain; resets to the idle (high) line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  // Shift the raw pin through the synchronizer flops.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: bit timing, sampling decisions and output pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Any low level on the synchronized line starts a frame.
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == HALF_LAST) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            bitn_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        // One full bit later is the middle of the next data bit.
        if (cnt_q == BIT_LAST) begin
          shreg_d = {rxs, shreg_q[7:1]};
          cnt_d   = '0;
          if (bitn_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        // Good stop bit delivers the byte; a low stop bit is a framing error.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        // Wait for the line to return high so a held-low line is not
        // mistaken for a new start bit.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign rx_valid     = valid_q;
  assign rx_data      = data_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;
  assign dbg_state    = state_q;

  // Pulse outputs are exclusive and never stretch over two cycles.
  a_pulse_exclusive : assert property (@(posedge clk) disable iff (i_reset)
    !(rx_valid && rx_frame_err));
  a_valid_single : assert property (@(posedge clk) disable iff (i_reset)
    rx_valid |=> !rx_valid);
  a_ferr_single : assert property (@(posedge clk) disable iff (i_reset)
    rx_frame_err |=> !rx_frame_err);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with CLKS_PER_BIT=16, SYNC_STAGES=2.
// A frame-level reference model derives the expected outputs on every cycle
// from the recorded line level. It works from the absolute sample times
// measured from the detected start of each frame. A byte scoreboard and
// literal checks cover the directed scenarios.

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int H    = CPB / 2;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_busy;
  logic [2:0] dbg_state;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int last_valid_cyc = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] ram [0:3];
  bit          ram_en   = 1'b0;
  int          ram_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs after each rising edge.
  logic       e_valid, e_ferr, e_busy;
  logic [7:0] e_data;

  initial begin
    bit         hist_rst[$];
    logic       hist_line[$];
    int         mode;   // 0 hunting for start, 1 inside a frame, 2 waiting for line high
    int         f;      // edge at which the frame's low level was first seen
    int         k;
    logic       obs;
    logic [7:0] m_byte;
    mode = 0; f = 0; m_byte = '0;
    e_valid = 0; e_ferr = 0; e_busy = 0; e_data = '0;
    for (int i = 0; i < SYNC; i++) begin
      hist_rst.push_back(1'b1);
      hist_line.push_back(1'b1);
    end
    forever begin
      @(posedge clk);
      cyc++;
      // Line level the receiver sees at this edge: SYNC edges old, forced
      // high if a reset edge happened since then.
      obs = hist_line[0];
      foreach (hist_rst[i]) if (hist_rst[i]) obs = 1'b1;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      if (i_reset) begin
        mode   = 0;
        e_data = '0;
      end else begin
        case (mode)
          0: if (!obs) begin mode = 1; f = cyc; end
          1: begin
            k = cyc - f;
            if (k == H) begin
              if (obs) mode = 0;
            end else if (k > H && k < H + 9 * CPB && (k - H) % CPB == 0) begin
              m_byte[(k - H) / CPB - 1] = obs;
            end else if (k == H + 9 * CPB) begin
              if (obs) begin
                e_valid = 1'b1;
                e_data  = m_byte;
                mode    = 0;
              end else begin
                e_ferr = 1'b1;
                mode   = 2;
              end
            end
          end
          default: if (obs) mode = 0;
        endcase
      end
      e_busy = (mode != 0);
      hist_line.push_back(i_rx);
      hist_rst.push_back(i_reset);
      void'(hist_line.pop_front());
      void'(hist_rst.pop_front());
    end
  end

  // ---------------- compare / scoreboard ----------------
  initial begin
    logic [7:0] expb;
    forever begin
      @(negedge clk);
      vectors++;
      if (rx_valid !== e_valid || rx_frame_err !== e_ferr ||
          rx_busy !== e_busy || rx_data !== e_data) begin
        miscompares++;
        $display("FAIL cycle %0d: valid %b ferr %b busy %b data %h, model wants valid %b ferr %b busy %b data %h",
                 cyc, rx_valid, rx_frame_err, rx_busy, rx_data, e_valid, e_ferr, e_busy, e_data);
      end
      if (rx_frame_err === 1'b1) ferr_cnt++;
      if (rx_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got byte %h expected none", rx_data);
        end else begin
          expb = exp_q.pop_front();
          check("sb_data", {24'h0, rx_data}, {24'h0, expb});
        end
        if (ram_en) begin
          ram[ram_addr >> 2][8 * (ram_addr % 4) +: 8] = rx_data;
          ram_addr++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic line_for(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    line_for(1'b0, CPB);
    for (int i = 0; i < 8; i++) line_for(b[i], CPB);
    line_for(stop_bit, stop_len);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, CPB);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, f0, drive_cyc, rise_cyc;
    logic [7:0] c3, b;
    int kind, gap;
    c3 = 8'hC3;
    for (int i = 0; i < 4; i++) ram[i] = '0;

    i_reset = 1'b1;
    i_rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_ferr",  {31'h0, rx_frame_err}, 32'h0);
    check("reset_busy",  {31'h0, rx_busy}, 32'h0);
    check("reset_data",  {24'h0, rx_data}, 32'h0);
    i_reset = 1'b0;
    line_for(1'b1, 10);

    // 1: single byte, latency from drive edge = 2 sync + 153 - 1 + 1
    v0 = valid_cnt; f0 = ferr_cnt;
    drive_cyc = cyc;
    send_good(8'hA5);
    line_for(1'b1, 10);
    check("t1_count",   valid_cnt - v0, 1);
    check("t1_latency", last_valid_cyc - drive_cyc, 155);
    check("t1_data",    {24'h0, rx_data}, 32'hA5);
    check("t1_ferr",    ferr_cnt - f0, 0);

    // 2: back-to-back frames with no idle gap
    v0 = valid_cnt;
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h41);
    line_for(1'b1, 20);
    check("t2_count", valid_cnt - v0, 3);
    check("t2_data",  {24'h0, rx_data}, 32'h41);

    // 3: short low glitch is rejected
    v0 = valid_cnt; f0 = ferr_cnt;
    line_for(1'b0, 5);
    rise_cyc = cyc;
    line_for(1'b1, 9);
    check("t3_busy_low", {31'h0, rx_busy}, 32'h0);
    check("t3_gap", cyc - rise_cyc, 9);
    line_for(1'b1, 10);
    check("t3_no_pulse", valid_cnt - v0 + ferr_cnt - f0, 0);
    send_good(8'h3C);
    line_for(1'b1, 10);
    check("t3_data", {24'h0, rx_data}, 32'h3C);

    // 4: bad stop bit with line held low afterwards
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, CPB + 40);
    check("t4_ferr",  ferr_cnt - f0, 1);
    check("t4_valid", valid_cnt - v0, 0);
    check("t4_data",  {24'h0, rx_data}, 32'h3C);
    check("t4_busy_held", {31'h0, rx_busy}, 32'h1);
    line_for(1'b1, 10);
    check("t4_busy_release", {31'h0, rx_busy}, 32'h0);
    send_good(8'h12);
    line_for(1'b1, 10);
    check("t4_next", {24'h0, rx_data}, 32'h12);

    // 5: reset in the middle of the data bits
    v0 = valid_cnt;
    line_for(1'b0, CPB);
    for (int i = 0; i < 3; i++) line_for(c3[i], CPB);
    line_for(c3[3], 8);
    i_reset = 1'b1;
    i_rx    = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("t5_valid", {31'h0, rx_valid}, 32'h0);
    check("t5_ferr",  {31'h0, rx_frame_err}, 32'h0);
    check("t5_busy",  {31'h0, rx_busy}, 32'h0);
    check("t5_data",  {24'h0, rx_data}, 32'h0);
    line_for(1'b1, 30);
    send_good(8'h7E);
    line_for(1'b1, 10);
    check("t5_count", valid_cnt - v0, 1);
    check("t5_next",  {24'h0, rx_data}, 32'h7E);

    // 6: program-RAM download, little-endian word packing
    v0 = valid_cnt;
    ram_en = 1'b1;
    ram_addr = 0;
    send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
    send_good(8'hFF); send_good(8'hFF); send_good(8'hFF); send_good(8'hFF);
    line_for(1'b1, 10);
    ram_en = 1'b0;
    check("t6_count", valid_cnt - v0, 8);
    check("t6_word0", ram[0], 32'h04030201);
    check("t6_word1", ram[1], 32'hFFFFFFFF);

    // Randomized mix of good frames, framing errors and glitches
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      b    = 8'($urandom_range(0, 255));
      if (kind <= 6) begin
        gap = $urandom_range(0, 12);
        line_for(1'b1, gap);
        send_good(b);
      end else if (kind <= 8) begin
        send_frame(b, 1'b0, CPB + $urandom_range(0, 30));
        line_for(1'b1, $urandom_range(4, 15));
      end else begin
        line_for(1'b0, $urandom_range(1, 7));
        line_for(1'b1, $urandom_range(20, 30));
      end
    end
    line_for(1'b1, 40);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
